// File: rtl/mode_decode.sv
// Byte-serial decoder for the TFTP transfer-mode field ("octet", "netascii", "mail"
// in any case, NUL-terminated). Accepts "octet" only; the other known modes decode as unsupported.
module mode_decode #(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] eth_data,
  output logic       valid,
  output logic       done,
  output logic       err,
  output logic [1:0] mode
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  // Candidates are left-justified and zero-padded, so any position past a
  // candidate's length holds 0x00. A non-NUL byte can never match there.
  localparam logic [63:0] OCTET_S    = {"octet", 24'h0};
  localparam logic [63:0] NETASCII_S = "netascii";
  localparam logic [63:0] MAIL_S     = {"mail", 32'h0};
  localparam int OCTET_LEN    = 5;
  localparam int NETASCII_LEN = 8;
  localparam int MAIL_LEN     = 4;

  typedef enum logic {ST_MATCH, ST_DONE} state_e;
  typedef enum logic [1:0] {
    MODE_NONE     = 2'b00,
    MODE_OCTET    = 2'b01,
    MODE_NETASCII = 2'b10,
    MODE_MAIL     = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       match_q, match_d;  // {mail, netascii, octet}
  logic [7:0]       folded;

  function automatic logic [7:0] char_at(input logic [63:0] s, input logic [IDX_W-1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (int'(idx) == i) c = s[63-8*i -: 8];
    end
    return c;
  endfunction

  always_comb begin
    folded = (eth_data >= 8'h41 && eth_data <= 8'h5A) ? (eth_data | 8'h20) : eth_data;
  end

  // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    idx_d   = idx_q;
    match_d = match_q;

    case (state_q)
      ST_MATCH: begin
        if (en) begin
          if (eth_data == 8'h00) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (match_q[0] && int'(idx_q) == OCTET_LEN) begin
              mode_d  = MODE_OCTET;
              valid_d = 1'b1;
            end else if (match_q[1] && int'(idx_q) == NETASCII_LEN) begin
              mode_d = MODE_NETASCII;
              err_d  = 1'b1;
            end else if (match_q[2] && int'(idx_q) == MAIL_LEN) begin
              mode_d = MODE_MAIL;
              err_d  = 1'b1;
            end else begin
              mode_d = MODE_NONE;
              err_d  = 1'b1;
            end
          end else if (idx_q == IDX_W'(MAX_LEN)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            match_d[0] = match_q[0] && (char_at(OCTET_S, idx_q) == folded);
            match_d[1] = match_q[1] && (char_at(NETASCII_S, idx_q) == folded);
            match_d[2] = match_q[2] && (char_at(MAIL_S, idx_q) == folded);
            idx_d      = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;  // ST_DONE holds everything until reset
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_MATCH;
      mode_q  <= MODE_NONE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      match_q <= 3'b111;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      match_q <= match_d;
    end
  end

  assign valid = valid_q;
  assign done  = done_q;
  assign err   = err_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_mode_decode.sv
// Directed bench for mode_decode: expected outputs are queued with each stimulus step
// and compared against the registered outputs one time unit after the sampling edge.
module tb_mode_decode;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] eth_data = 8'h00;
  logic       valid, done, err;
  logic [1:0] mode;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic       d;
    logic       e;
    logic [1:0] m;
  } exp_t;

  exp_t sb[$];

  mode_decode #(.MAX_LEN(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .eth_data (eth_data),
    .valid    (valid),
    .done     (done),
    .err      (err),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic d, input logic e,
                            input logic [1:0] m);
    exp_t x;
    x.tag = tag; x.v = v; x.d = d; x.e = e; x.m = m;
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, ".valid"}, {1'b0, valid}, {1'b0, x.v});
      check({x.tag, ".done"},  {1'b0, done},  {1'b0, x.d});
      check({x.tag, ".err"},   {1'b0, err},   {1'b0, x.e});
      check({x.tag, ".mode"},  mode,          x.m);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    en       = 1'b1;
    eth_data = b;
    @(posedge clk);
    #1;
    en       = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic stall(input int cycles);
    en       = 1'b0;
    eth_data = 8'h00;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_out(tag, 1'b0, 1'b0, 1'b0, 2'b00);
    compare_out();
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // lowercase octet, with a check one byte before the terminator
    do_reset("reset0");
    send_str("octet");
    expect_out("octet_pre_nul", 1'b0, 1'b0, 1'b0, 2'b00);
    compare_out();
    send_byte(8'h00);
    expect_out("octet", 1'b1, 1'b1, 1'b0, 2'b01);
    compare_out();

    do_reset("reset1");
    send_str("OCTET");
    send_byte(8'h00);
    expect_out("OCTET", 1'b1, 1'b1, 1'b0, 2'b01);
    compare_out();

    // netascii is exactly MAX_LEN characters long
    do_reset("reset2");
    send_str("netascii");
    send_byte(8'h00);
    expect_out("netascii", 1'b0, 1'b1, 1'b1, 2'b10);
    compare_out();

    do_reset("reset3");
    send_str("mAiL");
    send_byte(8'h00);
    expect_out("mail", 1'b0, 1'b1, 1'b1, 2'b11);
    compare_out();

    do_reset("reset4");
    send_str("oct");
    send_byte(8'h00);
    expect_out("oct_short", 1'b0, 1'b1, 1'b1, 2'b00);
    compare_out();

    do_reset("reset5");
    send_str("octetx");
    send_byte(8'h00);
    expect_out("octet_long", 1'b0, 1'b1, 1'b1, 2'b00);
    compare_out();

    do_reset("reset6");
    send_byte(8'h00);
    expect_out("nul_first", 1'b0, 1'b1, 1'b1, 2'b00);
    compare_out();

    // overflow: the 9th non-NUL byte terminates with an error
    do_reset("reset7");
    send_str("aaaaaaaa");
    expect_out("ovf_8th", 1'b0, 1'b0, 1'b0, 2'b00);
    compare_out();
    send_byte(8'h61);
    expect_out("ovf_9th", 1'b0, 1'b1, 1'b1, 2'b00);
    compare_out();

    // stall with NUL on the bus while en=0, then finish the string
    do_reset("reset8");
    send_str("oc");
    for (int i = 0; i < 3; i++) begin
      stall(1);
      expect_out("stall", 1'b0, 1'b0, 1'b0, 2'b00);
      compare_out();
    end
    send_str("tet");
    expect_out("stall_pre_nul", 1'b0, 1'b0, 1'b0, 2'b00);
    compare_out();
    send_byte(8'h00);
    expect_out("stall_octet", 1'b1, 1'b1, 1'b0, 2'b01);
    compare_out();

    // bytes after done are ignored
    send_str("mail");
    send_byte(8'h00);
    expect_out("after_done", 1'b1, 1'b1, 1'b0, 2'b01);
    compare_out();

    // asynchronous reset between clock edges clears the outputs at once
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 1'b0, 2'b00);
    compare_out();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // reset mid-string, then a complete octet decodes from index 0
    send_str("oct");
    do_reset("mid_reset");
    send_str("octet");
    send_byte(8'h00);
    expect_out("octet_after_mid_reset", 1'b1, 1'b1, 1'b0, 2'b01);
    compare_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_decode.md
Name: mode_decode

Overview:
- Byte-serial decoder for the TFTP transfer-mode field (RFC 1350) in the RX path.
- Sits after filename extraction in a RRQ/WRQ packet. Fed one payload byte per enabled clock, starting at the first mode character.
- Recognises the mode strings "octet", "netascii" and "mail" (case-insensitive) terminated by NUL 0x00.
- Flags acceptance for the server's supported mode "octet", and reports the decoded mode or an error.

Parameters:
- MAX_LEN, 8, maximum mode characters before the NUL terminator; a longer string is an error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state and outputs.
- en  input  1  byte strobe; eth_data is consumed on a rising edge only while en=1.
- eth_data  input  8  current mode-field byte.
- valid  output  1  registered; 1 = mode string was exactly "octet"+NUL (any case).
- done  output  1  registered; 1 = NUL received or error detected; decode finished.
- err  output  1  registered; 1 = string malformed or unsupported.
- mode  output  2  registered decoded mode: 00 none/unknown, 01 octet, 10 netascii, 11 mail.

Behaviour:
- Reset (async, asserted): valid=0, done=0, err=0, mode=00, character index=0, all candidate-match flags=1. One decode per reset; upstream pulses reset per packet.
- Case folding: bytes 0x41..0x5A have bit 5 set before comparison. Other bytes are compared unchanged.
- Matching:
  - Keep one match flag per candidate (octet, netascii, mail) and a character index 0..MAX_LEN.
  - On each enabled non-NUL byte: clear each candidate flag whose character at the current index differs from the folded byte, or whose length is already reached. Then increment the index.
  - States: IDLE/MATCHING (index 0..MAX_LEN, done=0) and DONE (done=1).
  - In DONE, all inputs are ignored and outputs hold until reset.
- NUL byte with en=1 while MATCHING, on the same rising edge:
  - Select the candidate whose flag is set and whose length equals the index.
  - octet: mode=01, valid=1.
  - netascii: mode=10, valid=0, err=1 (unsupported).
  - mail: mode=11, valid=0, err=1 (unsupported).
  - No candidate: mode=00, err=1.
  - done=1 in every case.
- Latency:
  - valid/done are high in the cycle after the edge that samples the NUL.
  - For "octet"+NUL presented on 6 consecutive enabled edges, valid=1 immediately after the 6th edge.
- Error conditions:
  - NUL as the first byte (index 0): err=1, done=1, mode=00.
  - Index reaches MAX_LEN with a non-NUL byte: err=1, done=1 on that edge.
  - All candidate flags cleared before the NUL: keep consuming bytes (no early error). The error is raised at the NUL or at the MAX_LEN overflow.
- en=0: hold all state (stall); decoding resumes on the next enabled byte. Gaps do not affect the result.
- Reset asserted mid-string: immediate clear; the next enabled byte is treated as index 0.
- Outputs are purely registered; no combinational path from eth_data to outputs.

Test Plan:
- reset high 1 cycle, then en=1 feeding 6F 63 74 65 74 00 one per edge -> after 6th edge valid=1, done=1, err=0, mode=01.
- Feed 4F 43 54 45 54 00 ("OCTET") -> valid=1, mode=01, err=0.
- Feed "netascii"+00 (6E 65 74 61 73 63 69 69 00) -> valid=0, err=1, done=1, mode=10. Feed "mail"+00 -> valid=0, err=1, mode=11.
- Feed 6F 63 74 00 ("oct") -> err=1, valid=0, mode=00. Feed 00 first -> err=1, done=1. Feed 9 non-NUL bytes -> err=1, done=1 on the 9th edge.
- "octet"+00 with en=0 for 3 cycles between 63 and 74 -> valid=1 only after the NUL edge, never earlier. Extra bytes after done leave outputs unchanged.
- Assert reset after 3 bytes of "octet", release, feed a full "octet"+00 -> all outputs 0 during reset, then valid=1 after the NUL.
